float_cmp_issuer: RTL and testbench

- Initiator/master side for the AXI-stream float compare unit; drives that unit's operand A and B slave streams and consumes its 8-bit result stream.
- Accepts tagged compare requests from a local controller, such as the FPGA-side program sequencer.
- Tracks in-flight operations in an in-order tag FIFO and returns each result (a < b flag) paired with its tag.
- Lets upstream logic issue compares back-to-back without knowing the compare unit's latency.

---
 rtl/float_cmp_issuer.sv | 171 +++++++++++++++++
 tb/tb_float_cmp_issuer.sv | 527 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_cmp_issuer.sv
// float_cmp_issuer
//
// Initiator for an AXI-stream float compare unit. Tagged compare requests
// from a local controller are split onto two independent operand streams
// (A and B). The request tag is parked in an in-order FIFO, and each result
// byte from the compare unit is paired with the oldest tag and presented
// as a response. Upstream logic can issue one compare per cycle without
// knowing the compare unit's latency. Only the FIFO depth limits it.
//
// Ports
//   aclk, aresetn          clock, async active-low reset
//   req_*                  request handshake, operands and tag
//   m_axis_a_* / m_axis_b_*  operand streams to the compare unit
//   s_axis_result_*        result stream from the compare unit (bit 0 = a<b)
//   rsp_*                  response handshake, lt flag and tag
//   outstanding            tags issued whose result has not yet returned
//   err                    sticky: a result arrived with no tag in flight

module float_cmp_issuer #(
    parameter int SIZE            = 32,
    parameter int TAG_W           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,

    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [SIZE-1:0]                      req_a,
    input  logic [SIZE-1:0]                      req_b,
    input  logic [TAG_W-1:0]                     req_tag,

    output logic [SIZE-1:0]                      m_axis_a_tdata,
    output logic                                 m_axis_a_tvalid,
    input  logic                                 m_axis_a_tready,
    output logic [SIZE-1:0]                      m_axis_b_tdata,
    output logic                                 m_axis_b_tvalid,
    input  logic                                 m_axis_b_tready,

    input  logic [7:0]                           s_axis_result_tdata,
    input  logic                                 s_axis_result_tvalid,
    output logic                                 s_axis_result_tready,

    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic                                 rsp_lt,
    output logic [TAG_W-1:0]                     rsp_tag,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic             req_fire;
    logic             a_fire;
    logic             b_fire;
    logic             res_fire;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [TAG_W-1:0] tag_mem [MAX_OUTSTANDING];

    // Only the lt flag is meaningful in the result byte.
    logic             unused_res_bits;
    assign unused_res_bits = ^s_axis_result_tdata[7:1];

    assign a_fire   = m_axis_a_tvalid && m_axis_a_tready;
    assign b_fire   = m_axis_b_tvalid && m_axis_b_tready;
    assign res_fire = s_axis_result_tvalid && s_axis_result_tready;

    // tready feeds req_ready combinationally so that a channel draining in
    // the same cycle can be reloaded without a bubble.
    assign req_ready = (!m_axis_a_tvalid || m_axis_a_tready) &&
                       (!m_axis_b_tvalid || m_axis_b_tready) &&
                       (outstanding < CNT_MAX);
    assign req_fire  = req_valid && req_ready;

    assign s_axis_result_tready = !rsp_valid || rsp_ready;

    // The outstanding counter doubles as the FIFO occupancy.
    assign fifo_empty = (outstanding == '0);
    assign push       = req_fire;
    assign pop        = res_fire && !fifo_empty;

    // Operand channels: valid flags are reset, data is don't-care.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_a_tvalid <= 1'b0;
            m_axis_b_tvalid <= 1'b0;
        end else begin
            if (req_fire) begin
                m_axis_a_tvalid <= 1'b1;
            end else if (a_fire) begin
                m_axis_a_tvalid <= 1'b0;
            end
            if (req_fire) begin
                m_axis_b_tvalid <= 1'b1;
            end else if (b_fire) begin
                m_axis_b_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (req_fire) begin
            m_axis_a_tdata <= req_a;
            m_axis_b_tdata <= req_b;
        end
    end

    // Tag FIFO storage; contents are don't-care after reset because the
    // pointers and counter define what is valid.
    always_ff @(posedge aclk) begin
        if (push) begin
            tag_mem[wr_ptr] <= req_tag;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (pop && !push) begin
                outstanding <= outstanding - CNT_W'(1);
            end
        end
    end

    // Response register. A result can be captured in the same cycle the
    // previous response is taken, which keeps the response path at full rate.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_tag   <= '0;
        end else begin
            if (pop) begin
                rsp_valid <= 1'b1;
                rsp_lt    <= s_axis_result_tdata[0];
                rsp_tag   <= tag_mem[rd_ptr];
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // A result with no tag in flight is swallowed and flagged until reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err <= 1'b0;
        end else if (res_fire && fifo_empty) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_float_cmp_issuer.sv
module tb_float_cmp_issuer;

    localparam int SIZE  = 32;
    localparam int TAG_W = 4;
    localparam int MAXO  = 4;
    localparam int CNT_W = $clog2(MAXO + 1);

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              req_valid;
    logic              req_ready;
    logic [SIZE-1:0]   req_a;
    logic [SIZE-1:0]   req_b;
    logic [TAG_W-1:0]  req_tag;
    logic [SIZE-1:0]   a_tdata;
    logic              a_tvalid;
    logic              a_tready;
    logic [SIZE-1:0]   b_tdata;
    logic              b_tvalid;
    logic              b_tready;
    logic [7:0]        s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_lt;
    logic [TAG_W-1:0]  rsp_tag;
    logic [CNT_W-1:0]  outstanding;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             lt;
    } exp_t;

    exp_t            exp_q[$];
    logic [SIZE-1:0] a_q[$];
    logic [SIZE-1:0] b_q[$];
    logic            res_q[$];

    float_cmp_issuer #(.SIZE(SIZE), .TAG_W(TAG_W), .MAX_OUTSTANDING(MAXO)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_a                (req_a),
        .req_b                (req_b),
        .req_tag              (req_tag),
        .m_axis_a_tdata       (a_tdata),
        .m_axis_a_tvalid      (a_tvalid),
        .m_axis_a_tready      (a_tready),
        .m_axis_b_tdata       (b_tdata),
        .m_axis_b_tvalid      (b_tvalid),
        .m_axis_b_tready      (b_tready),
        .s_axis_result_tdata  (s_tdata),
        .s_axis_result_tvalid (s_tvalid),
        .s_axis_result_tready (s_tready),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_lt               (rsp_lt),
        .rsp_tag              (rsp_tag),
        .outstanding          (outstanding),
        .err                  (err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference: ordinary (non-zero, non-NaN) IEEE single compare a < b.
    function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(1, 254));
        m = 23'($urandom);
        return {s, e, m};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        a_tready  = 1'b1;
        b_tready  = 1'b1;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        rsp_ready = 1'b1;
        aresetn   = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({a_tvalid, b_tvalid, rsp_valid, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got a/b/rsp/err=%b expected 0000", {a_tvalid, b_tvalid, rsp_valid, err});
        end
        n_tests++;
        if (outstanding !== '0) begin
            n_fail++;
            $display("FAIL reset_outstanding: got %0d expected 0", outstanding);
        end
        n_tests++;
        if ({req_ready, s_tready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_readies: got req/res=%b expected 11", {req_ready, s_tready});
        end
    endtask

    task automatic test_single_op();
        do_reset();
        req_valid = 1'b1;
        req_a     = 32'h3F800000;
        req_b     = 32'h40000000;
        req_tag   = 4'd5;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_req_ready: got %b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        #1;
        n_tests++;
        if ({a_tvalid, b_tvalid, a_tdata, b_tdata} !== {2'b11, 32'h3F800000, 32'h40000000}) begin
            n_fail++;
            $display("FAIL single_channels: got v=%b a=%h b=%h expected v=11 a=3f800000 b=40000000",
                     {a_tvalid, b_tvalid}, a_tdata, b_tdata);
        end
        n_tests++;
        if (outstanding !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL single_outstanding_1: got %0d expected 1", outstanding);
        end
        tick();
        n_tests++;
        if ({a_tvalid, b_tvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_channels_drained: got %b expected 00", {a_tvalid, b_tvalid});
        end
        tick();
        s_tvalid = 1'b1;
        s_tdata  = 8'h01;
        #1;
        n_tests++;
        if ({s_tready, rsp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_pre_result: got tready/rsp_valid=%b expected 10", {s_tready, rsp_valid});
        end
        tick();
        s_tvalid = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid, rsp_lt, rsp_tag} !== {1'b1, 1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b lt=%b tag=%0d expected v=1 lt=1 tag=5", rsp_valid, rsp_lt, rsp_tag);
        end
        n_tests++;
        if (outstanding !== '0) begin
            n_fail++;
            $display("FAIL single_outstanding_0: got %0d expected 0", outstanding);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp_clear: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_tag   = TAG_W'(i);
            req_a     = rand_fp();
            req_b     = rand_fp();
            #1;
            n_tests++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_accept_%0d: got req_ready=%b expected 1", i, req_ready);
            end
            exp_q.push_back({req_tag, fp_lt(req_a, req_b)});
            tick();
        end
        req_tag = 4'd4;
        req_a   = rand_fp();
        req_b   = rand_fp();
        tick();
        tick();
        n_tests++;
        if ({req_ready, outstanding} !== {1'b0, CNT_W'(4)}) begin
            n_fail++;
            $display("FAIL b2b_full: got req_ready=%b outstanding=%0d expected 0 and 4", req_ready, outstanding);
        end
        s_tvalid = 1'b1;
        s_tdata  = {7'($urandom), exp_q[0].lt};
        tick();
        s_tvalid = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if ({rsp_valid, rsp_tag, rsp_lt} !== {1'b1, e.tag, e.lt}) begin
            n_fail++;
            $display("FAIL b2b_first_rsp: got v=%b tag=%0d lt=%b expected v=1 tag=%0d lt=%b",
                     rsp_valid, rsp_tag, rsp_lt, e.tag, e.lt);
        end
        n_tests++;
        if ({req_ready, outstanding} !== {1'b1, CNT_W'(3)}) begin
            n_fail++;
            $display("FAIL b2b_reenable: got req_ready=%b outstanding=%0d expected 1 and 3", req_ready, outstanding);
        end
        exp_q.push_back({req_tag, fp_lt(req_a, req_b)});
        tick();
        req_valid = 1'b0;
        n_tests++;
        if (outstanding !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL b2b_fifth_accept: got outstanding=%0d expected 4", outstanding);
        end
        for (int k = 0; k < 4; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = {7'($urandom), exp_q[0].lt};
            tick();
            s_tvalid = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if ({rsp_valid, rsp_tag, rsp_lt} !== {1'b1, e.tag, e.lt}) begin
                n_fail++;
                $display("FAIL b2b_drain_%0d: got v=%b tag=%0d lt=%b expected v=1 tag=%0d lt=%b",
                         k, rsp_valid, rsp_tag, rsp_lt, e.tag, e.lt);
            end
        end
        tick();
        n_tests++;
        if ({rsp_valid, outstanding} !== {1'b0, CNT_W'(0)}) begin
            n_fail++;
            $display("FAIL b2b_idle: got rsp_valid=%b outstanding=%0d expected 0 and 0", rsp_valid, outstanding);
        end
    endtask

    task automatic test_skewed();
        logic [31:0] ra, rb, na, nb;
        logic [4:0]  exp_rsp [2];
        do_reset();
        ra = rand_fp(); rb = rand_fp(); na = rand_fp(); nb = rand_fp();
        a_tready  = 1'b1;
        b_tready  = 1'b0;
        req_valid = 1'b1;
        req_a     = ra;
        req_b     = rb;
        req_tag   = 4'd7;
        tick();
        req_a   = na;
        req_b   = nb;
        req_tag = 4'd8;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if ({a_tvalid, b_tvalid, b_tdata, req_ready} !== {(c == 0), 1'b1, rb, 1'b0}) begin
                n_fail++;
                $display("FAIL skew_hold_%0d: got a_v=%b b_v=%b b_data=%h req_ready=%b expected a_v=%b b_v=1 b_data=%h req_ready=0",
                         c, a_tvalid, b_tvalid, b_tdata, req_ready, (c == 0), rb);
            end
            tick();
        end
        b_tready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL skew_release: got req_ready=%b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        n_tests++;
        if ({a_tvalid, b_tvalid, a_tdata, b_tdata, outstanding} !== {2'b11, na, nb, CNT_W'(2)}) begin
            n_fail++;
            $display("FAIL skew_reload: got v=%b a=%h b=%h out=%0d expected v=11 a=%h b=%h out=2",
                     {a_tvalid, b_tvalid}, a_tdata, b_tdata, outstanding, na, nb);
        end
        tick();
        exp_rsp[0] = {4'd7, fp_lt(ra, rb)};
        exp_rsp[1] = {4'd8, fp_lt(na, nb)};
        for (int k = 0; k < 2; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = {7'($urandom), exp_rsp[k][0]};
            tick();
            s_tvalid = 1'b0;
            n_tests++;
            if ({rsp_valid, rsp_tag, rsp_lt} !== {1'b1, exp_rsp[k]}) begin
                n_fail++;
                $display("FAIL skew_rsp_%0d: got v=%b tag=%0d lt=%b expected v=1 tag/lt=%b",
                         k, rsp_valid, rsp_tag, rsp_lt, exp_rsp[k]);
            end
        end
    endtask

    task automatic test_rsp_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_a = rand_fp(); req_b = rand_fp(); req_tag = 4'd1;
        tick();
        req_a = rand_fp(); req_b = rand_fp(); req_tag = 4'd2;
        tick();
        req_valid = 1'b0;
        tick();
        s_tvalid = 1'b1;
        s_tdata  = 8'h00;
        tick();
        s_tdata  = 8'h01;
        #1;
        n_tests++;
        if ({rsp_valid, rsp_lt, rsp_tag, s_tready} !== {1'b1, 1'b0, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_first_held: got v=%b lt=%b tag=%0d res_tready=%b expected v=1 lt=0 tag=1 res_tready=0",
                     rsp_valid, rsp_lt, rsp_tag, s_tready);
        end
        tick();
        tick();
        n_tests++;
        if ({rsp_valid, rsp_lt, rsp_tag, outstanding} !== {1'b1, 1'b0, 4'd1, CNT_W'(1)}) begin
            n_fail++;
            $display("FAIL bp_still_held: got v=%b lt=%b tag=%0d out=%0d expected v=1 lt=0 tag=1 out=1",
                     rsp_valid, rsp_lt, rsp_tag, outstanding);
        end
        rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_tready_reopen: got %b expected 1", s_tready);
        end
        tick();
        s_tvalid = 1'b0;
        n_tests++;
        if ({rsp_valid, rsp_lt, rsp_tag} !== {1'b1, 1'b1, 4'd2}) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b lt=%b tag=%0d expected v=1 lt=1 tag=2", rsp_valid, rsp_lt, rsp_tag);
        end
        tick();
        n_tests++;
        if ({rsp_valid, outstanding} !== {1'b0, CNT_W'(0)}) begin
            n_fail++;
            $display("FAIL bp_done: got v=%b out=%0d expected 0 and 0", rsp_valid, outstanding);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        s_tvalid = 1'b1;
        s_tdata  = 8'h01;
        tick();
        s_tvalid = 1'b0;
        n_tests++;
        if ({err, rsp_valid, outstanding} !== {1'b1, 1'b0, CNT_W'(0)}) begin
            n_fail++;
            $display("FAIL spurious: got err=%b v=%b out=%0d expected 1 0 0", err, rsp_valid, outstanding);
        end
        repeat (3) tick();
        n_tests++;
        if ({err, rsp_valid, outstanding} !== {1'b1, 1'b0, CNT_W'(0)}) begin
            n_fail++;
            $display("FAIL spurious_sticky: got err=%b v=%b out=%0d expected 1 0 0", err, rsp_valid, outstanding);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        s_tvalid = 1'b1;
        s_tdata  = 8'h00;
        tick();
        s_tvalid  = 1'b0;
        req_valid = 1'b1;
        req_a = rand_fp(); req_b = rand_fp(); req_tag = 4'd3;
        tick();
        req_tag = 4'd4;
        tick();
        req_valid = 1'b0;
        a_tready  = 1'b0;
        n_tests++;
        if ({a_tvalid, outstanding, err} !== {1'b1, CNT_W'(2), 1'b1}) begin
            n_fail++;
            $display("FAIL arst_setup: got a_v=%b out=%0d err=%b expected 1 2 1", a_tvalid, outstanding, err);
        end
        #2 aresetn = 1'b0;
        #1;
        n_tests++;
        if ({a_tvalid, b_tvalid, rsp_valid, outstanding, err, req_ready} !==
            {1'b0, 1'b0, 1'b0, CNT_W'(0), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL arst_immediate: got a_v=%b b_v=%b rsp_v=%b out=%0d err=%b req_ready=%b expected 0 0 0 0 0 1",
                     a_tvalid, b_tvalid, rsp_valid, outstanding, err, req_ready);
        end
        @(posedge aclk);
        @(negedge aclk);
        aresetn  = 1'b1;
        a_tready = 1'b1;
        tick();
        s_tvalid = 1'b1;
        s_tdata  = 8'h01;
        tick();
        s_tvalid = 1'b0;
        n_tests++;
        if ({err, rsp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL arst_stale: got err=%b rsp_v=%b expected 1 0", err, rsp_valid);
        end
    endtask

    // Random traffic against a model of the issuer plus an in-order compare
    // unit that pairs A and B operands as they leave the channels.
    task automatic test_random();
        exp_t e;
        int   model_out;
        bit   fire_s;
        bit   done;
        do_reset();
        exp_q.delete(); a_q.delete(); b_q.delete(); res_q.delete();
        model_out = 0;
        done      = 0;
        for (int cyc = 0; cyc < 1200 && !done; cyc++) begin
            req_valid = (cyc < 800) && ($urandom_range(0, 3) != 0);
            req_a     = rand_fp();
            req_b     = rand_fp();
            req_tag   = TAG_W'($urandom);
            a_tready  = ($urandom_range(0, 3) != 0);
            b_tready  = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!s_tvalid && res_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                s_tvalid = 1'b1;
                s_tdata  = {7'($urandom), res_q[0]};
            end
            #1;
            n_tests++;
            if (outstanding !== CNT_W'(model_out)) begin
                n_fail++;
                $display("FAIL rand_outstanding cyc %0d: got %0d expected %0d", cyc, outstanding, model_out);
            end
            if (rsp_valid && rsp_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_unexpected_rsp cyc %0d: got tag=%0d, no response expected", cyc, rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_tag, rsp_lt} !== e) begin
                        n_fail++;
                        $display("FAIL rand_rsp cyc %0d: got tag=%0d lt=%b expected tag=%0d lt=%b",
                                 cyc, rsp_tag, rsp_lt, e.tag, e.lt);
                    end
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back({req_tag, fp_lt(req_a, req_b)});
                model_out++;
            end
            if (a_tvalid && a_tready) a_q.push_back(a_tdata);
            if (b_tvalid && b_tready) b_q.push_back(b_tdata);
            fire_s = s_tvalid && s_tready;
            if (fire_s) begin
                void'(res_q.pop_front());
                model_out--;
            end
            while (a_q.size() > 0 && b_q.size() > 0)
                res_q.push_back(fp_lt(a_q.pop_front(), b_q.pop_front()));
            tick();
            if (fire_s) s_tvalid = 1'b0;
            if (cyc >= 800 && exp_q.size() == 0 && res_q.size() == 0 && !a_tvalid && !b_tvalid && !rsp_valid)
                done = 1;
        end
        s_tvalid = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d responses still pending, expected 0", exp_q.size());
        end
        n_tests++;
        if ({err, outstanding} !== {1'b0, CNT_W'(0)}) begin
            n_fail++;
            $display("FAIL rand_final: got err=%b out=%0d expected 0 0", err, outstanding);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_skewed();
        test_rsp_backpressure();
        test_spurious();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
